// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Bundle of the fetch (F), load/store (D) and memory (M) handshake
//            signals shared between the memory port arbiter and its neighbours.
//            master = arbiter view, slave = requesters + memory view.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              f_en;
    logic              f_we;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_di;
    logic [DATA_W-1:0] f_do;
    logic              f_ack;
    logic              f_err;
    // load/store requester
    logic              d_en;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_di;
    logic [DATA_W-1:0] d_do;
    logic              d_ack;
    logic              d_err;
    // memory side
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_di;
    logic [DATA_W-1:0] m_do;
    logic              m_ack;
    // status
    logic [1:0]        grant;
    logic              busy;

    modport master (
        input  f_en, f_we, f_addr, f_di,
        input  d_en, d_we, d_addr, d_di,
        input  m_do, m_ack,
        output f_do, f_ack, f_err,
        output d_do, d_ack, d_err,
        output m_en, m_we, m_addr, m_di,
        output grant, busy
    );

    modport slave (
        output f_en, f_we, f_addr, f_di,
        output d_en, d_we, d_addr, d_di,
        output m_do, m_ack,
        input  f_do, f_ack, f_err,
        input  d_do, d_ack, d_err,
        input  m_en, m_we, m_addr, m_di,
        input  grant, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one memory port between the fetch (F)
//            and load/store (D) requesters. Holds a registered memory request
//            until m_ack, returns a one-cycle ack, and force-completes with an
//            error after TIMEOUT cycles without m_ack (TIMEOUT=0 disables).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256,
    parameter int TMR_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Last watchdog value before forced completion; guarded so TIMEOUT=0
    // does not underflow (the watchdog is disabled in that case anyway).
    localparam bit                TIMEOUT_EN = (TIMEOUT != 0);
    localparam int                LAST_INT   = TIMEOUT_EN ? (TIMEOUT - 1) : 0;
    localparam logic [TMR_W-1:0]  TMR_LAST   = LAST_INT[TMR_W-1:0];
    localparam logic [TMR_W-1:0]  TMR_ONE    = {{(TMR_W-1){1'b0}}, 1'b1};

    state_t            state,    state_nxt;
    logic              m_en,     m_en_nxt;
    logic              m_we,     m_we_nxt;
    logic [ADDR_W-1:0] m_addr,   m_addr_nxt;
    logic [DATA_W-1:0] m_di,     m_di_nxt;
    logic [DATA_W-1:0] f_do,     f_do_nxt;
    logic [DATA_W-1:0] d_do,     d_do_nxt;
    logic              f_ack,    f_ack_nxt;
    logic              d_ack,    d_ack_nxt;
    logic              f_err,    f_err_nxt;
    logic              d_err,    d_err_nxt;
    logic [1:0]        grant,    grant_nxt;
    logic              busy,     busy_nxt;
    logic              last_d,   last_d_nxt;   // 1: D was granted last
    logic [TMR_W-1:0]  wdog,     wdog_nxt;

    logic              pick_d;
    logic              done;
    logic              timed_out;

    // D wins when it is the only requester, or on a tie when F went last.
    assign pick_d    = bus.d_en && (!bus.f_en || !last_d);
    // Real m_ack always beats the watchdog in the same cycle.
    assign timed_out = TIMEOUT_EN && (wdog == TMR_LAST) && !bus.m_ack;
    assign done      = bus.m_ack || timed_out;

    // Next-state and next-output computation; every register defaults to hold.
    always_comb begin
        state_nxt  = state;
        m_en_nxt   = m_en;
        m_we_nxt   = m_we;
        m_addr_nxt = m_addr;
        m_di_nxt   = m_di;
        f_do_nxt   = f_do;
        d_do_nxt   = d_do;
        f_ack_nxt  = f_ack;
        d_ack_nxt  = d_ack;
        f_err_nxt  = f_err;
        d_err_nxt  = d_err;
        grant_nxt  = grant;
        last_d_nxt = last_d;
        wdog_nxt   = wdog;

        unique case (state)
            IDLE: begin
                m_en_nxt = 1'b0;
                if (bus.f_en || bus.d_en) begin
                    m_en_nxt   = 1'b1;
                    m_we_nxt   = pick_d ? bus.d_we   : bus.f_we;
                    m_addr_nxt = pick_d ? bus.d_addr : bus.f_addr;
                    m_di_nxt   = pick_d ? bus.d_di   : bus.f_di;
                    grant_nxt  = pick_d ? 2'b10 : 2'b01;
                    last_d_nxt = pick_d;
                    wdog_nxt   = '0;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                wdog_nxt = wdog + TMR_ONE;
                if (done) begin
                    m_en_nxt  = 1'b0;
                    state_nxt = RELEASE;
                    if (grant[0]) begin
                        f_do_nxt  = bus.m_ack ? bus.m_do : '0;
                        f_ack_nxt = 1'b1;
                        f_err_nxt = !bus.m_ack;
                    end else begin
                        d_do_nxt  = bus.m_ack ? bus.m_do : '0;
                        d_ack_nxt = 1'b1;
                        d_err_nxt = !bus.m_ack;
                    end
                end
            end
            RELEASE: begin
                f_ack_nxt = 1'b0;
                d_ack_nxt = 1'b0;
                f_err_nxt = 1'b0;
                d_err_nxt = 1'b0;
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
            default: begin
                m_en_nxt  = 1'b0;
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            m_en   <= 1'b0;
            m_we   <= 1'b0;
            m_addr <= '0;
            m_di   <= '0;
            f_do   <= '0;
            d_do   <= '0;
            f_ack  <= 1'b0;
            d_ack  <= 1'b0;
            f_err  <= 1'b0;
            d_err  <= 1'b0;
            grant  <= 2'b00;
            busy   <= 1'b0;
            last_d <= 1'b1;
            wdog   <= '0;
        end else begin
            state  <= state_nxt;
            m_en   <= m_en_nxt;
            m_we   <= m_we_nxt;
            m_addr <= m_addr_nxt;
            m_di   <= m_di_nxt;
            f_do   <= f_do_nxt;
            d_do   <= d_do_nxt;
            f_ack  <= f_ack_nxt;
            d_ack  <= d_ack_nxt;
            f_err  <= f_err_nxt;
            d_err  <= d_err_nxt;
            grant  <= grant_nxt;
            busy   <= busy_nxt;
            last_d <= last_d_nxt;
            wdog   <= wdog_nxt;
        end
    end

    assign bus.m_en   = m_en;
    assign bus.m_we   = m_we;
    assign bus.m_addr = m_addr;
    assign bus.m_di   = m_di;
    assign bus.f_do   = f_do;
    assign bus.d_do   = d_do;
    assign bus.f_ack  = f_ack;
    assign bus.d_ack  = d_ack;
    assign bus.f_err  = f_err;
    assign bus.d_err  = d_err;
    assign bus.grant  = grant;
    assign bus.busy   = busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter (TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int TMR_W   = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cnt;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL global_timeout observed=stalled expected=finished");
        $fatal(1, "bench stalled");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence; outputs sampled 1 ns after each rising edge.
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.f_en = 1'b0; bus.f_we = 1'b0; bus.f_addr = '0; bus.f_di = '0;
        bus.d_en = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_di = '0;
        bus.m_do = '0;   bus.m_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // ---- reset state
        chk("rst_m_en",  32'(bus.m_en),  32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_acks",  32'({bus.f_ack, bus.d_ack, bus.f_err, bus.d_err}), 32'd0);

        // ---- fetch read, memory acks on the 3rd m_en cycle
        bus.f_en = 1'b1; bus.f_addr = 10'h004;
        tick();
        chk("t1_m_en_rise", 32'(bus.m_en),   32'd1);
        chk("t1_grant",     32'(bus.grant),  32'd1);
        chk("t1_m_addr",    32'(bus.m_addr), 32'h004);
        chk("t1_m_we",      32'(bus.m_we),   32'd0);
        tick();
        chk("t1_m_en_c2",   32'(bus.m_en),   32'd1);
        tick();
        chk("t1_m_en_c3",   32'(bus.m_en),   32'd1);
        bus.m_ack = 1'b1; bus.m_do = 32'h12345678;
        tick();
        chk("t1_m_en_fall", 32'(bus.m_en),  32'd0);
        chk("t1_f_ack",     32'(bus.f_ack), 32'd1);
        chk("t1_f_do",      bus.f_do,       32'h12345678);
        chk("t1_f_err",     32'(bus.f_err), 32'd0);
        chk("t1_d_ack",     32'(bus.d_ack), 32'd0);
        chk("t1_grant_rel", 32'(bus.grant), 32'd1);
        bus.m_ack = 1'b0; bus.f_en = 1'b0;
        tick();
        chk("t1_ack_clr",   32'(bus.f_ack), 32'd0);
        chk("t1_grant_clr", 32'(bus.grant), 32'd0);
        chk("t1_busy_clr",  32'(bus.busy),  32'd0);
        // stray m_ack while idle must be ignored
        bus.m_ack = 1'b1; bus.m_do = 32'hFFFF0000;
        tick();
        chk("stray_ack_f_ack", 32'(bus.f_ack), 32'd0);
        chk("stray_ack_busy",  32'(bus.busy),  32'd0);
        chk("stray_ack_f_do",  bus.f_do,       32'h12345678);
        bus.m_ack = 1'b0;

        // ---- round robin from reset, memory acks in 1 cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.f_en = 1'b1; bus.d_en = 1'b1; bus.m_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.m_do = 32'h100 + 32'(i);
            tick();
            chk("rr_grant", 32'(bus.grant), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            chk("rr_ack", 32'({bus.d_ack, bus.f_ack}), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_do", (i % 2 == 0) ? bus.f_do : bus.d_do, 32'h100 + 32'(i));
            if (i % 2 == 0) bus.f_en = 1'b0; else bus.d_en = 1'b0;
            tick();
            chk("rr_idle_grant", 32'(bus.grant), 32'd0);
            if (i % 2 == 0) bus.f_en = 1'b1; else bus.d_en = 1'b1;
        end
        bus.f_en = 1'b0; bus.d_en = 1'b0; bus.m_ack = 1'b0;

        // ---- data write, d_di/d_addr changed mid-access
        bus.d_en = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h3FF; bus.d_di = 32'hCAFEF00D;
        tick();
        chk("wr_grant",  32'(bus.grant),  32'd2);
        chk("wr_m_we",   32'(bus.m_we),   32'd1);
        chk("wr_m_addr", 32'(bus.m_addr), 32'h3FF);
        chk("wr_m_di",   bus.m_di,        32'hCAFEF00D);
        bus.d_di = 32'hDEADBEEF; bus.d_addr = 10'h000;
        tick();
        chk("wr_m_di_hold",   bus.m_di,        32'hCAFEF00D);
        chk("wr_m_addr_hold", 32'(bus.m_addr), 32'h3FF);
        bus.m_ack = 1'b1; bus.m_do = 32'h0;
        tick();
        chk("wr_d_ack", 32'(bus.d_ack), 32'd1);
        chk("wr_f_ack", 32'(bus.f_ack), 32'd0);
        chk("wr_m_en",  32'(bus.m_en),  32'd0);
        bus.m_ack = 1'b0; bus.d_en = 1'b0; bus.d_we = 1'b0;
        tick();

        // ---- watchdog: data read never acked
        bus.d_en = 1'b1; bus.d_addr = 10'h055;
        tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.m_en !== 1'b1) break;
            cnt++;
            tick();
        end
        chk("to_m_en_cycles", 32'(cnt),         32'd8);
        chk("to_d_ack",       32'(bus.d_ack),   32'd1);
        chk("to_d_err",       32'(bus.d_err),   32'd1);
        chk("to_d_do",        bus.d_do,         32'h0);
        bus.d_en = 1'b0;
        tick();
        chk("to_clr", 32'({bus.d_ack, bus.d_err, bus.busy}), 32'd0);
        bus.f_en = 1'b1; bus.f_addr = 10'h010;
        tick();
        chk("to_next_grant", 32'(bus.grant), 32'd1);
        bus.m_ack = 1'b1; bus.m_do = 32'hA5A5A5A5;
        tick();
        chk("to_next_f_ack", 32'({bus.f_ack, bus.f_err}), 32'b10);
        chk("to_next_f_do",  bus.f_do, 32'hA5A5A5A5);
        bus.f_en = 1'b0; bus.m_ack = 1'b0;
        tick();

        // ---- reset in the middle of an access
        bus.f_en = 1'b1;
        tick(); tick();
        chk("rs_in_access", 32'(bus.m_en), 32'd1);
        reset = 1'b1; bus.f_en = 1'b0;
        tick();
        chk("rs_m_en", 32'(bus.m_en), 32'd0);
        reset = 1'b0; bus.m_ack = 1'b1; bus.m_do = 32'h77777777;
        tick();
        chk("rs_no_ack", 32'({bus.f_ack, bus.f_err, bus.d_ack, bus.d_err}), 32'd0);
        chk("rs_grant",  32'(bus.grant), 32'd0);
        chk("rs_busy",   32'(bus.busy),  32'd0);
        chk("rs_m_en2",  32'(bus.m_en),  32'd0);
        bus.m_ack = 1'b0;
        bus.f_en = 1'b1; bus.d_en = 1'b1;
        tick();
        chk("rs_tie_grant_f", 32'(bus.grant), 32'd1);
        bus.m_ack = 1'b1;
        tick();
        bus.f_en = 1'b0; bus.m_ack = 1'b0;
        tick();
        tick();
        chk("rs_then_d", 32'(bus.grant), 32'd2);
        bus.m_ack = 1'b1;
        tick();
        bus.d_en = 1'b0; bus.m_ack = 1'b0;
        tick();

        // ---- d_en rises during F release; ack and timeout coincide
        bus.f_en = 1'b1;
        tick();
        bus.m_ack = 1'b1;
        tick();
        chk("late_f_ack", 32'(bus.f_ack), 32'd1);
        bus.f_en = 1'b0; bus.m_ack = 1'b0; bus.d_en = 1'b1; bus.d_we = 1'b0;
        tick();
        chk("late_idle_grant", 32'(bus.grant), 32'd0);
        chk("late_idle_m_en",  32'(bus.m_en),  32'd0);
        tick();
        chk("late_d_grant", 32'(bus.grant), 32'd2);
        chk("late_d_m_en",  32'(bus.m_en),  32'd1);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.m_en === 1'b1) cnt++;
        end
        chk("race_m_en_held", 32'(cnt), 32'd7);
        bus.m_ack = 1'b1; bus.m_do = 32'h0BADCAFE;
        tick();
        chk("race_d_ack", 32'({bus.d_ack, bus.d_err}), 32'b10);
        chk("race_d_do",  bus.d_do, 32'h0BADCAFE);
        bus.m_ack = 1'b0; bus.d_en = 1'b0;
        tick();
        chk("race_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
